sample_framer: RTL and testbench
================================

Name: sample_framer

Overview:
- Downstream stage of the averaging datapath in the ring-oscillator temperature sensor.
- Accepts one 16-bit averaged measurement per handshake and serialises it as a fixed 5-byte frame: HEADER, SEQ, MSB, LSB, CHK.
- Drives the byte-level UART transmitter through its tx_start/tx_busy handshake, so the host receives self-delimiting, checksummed readings without byte-select polling.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- ACK_TIMEOUT, 64, clk cycles to wait for tx_busy to rise after tx_start before re-issuing the byte; minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- sample_in  input  16  averaged measurement.
- sample_valid  input  1  sample_in is valid.
- sample_ready  output  1  framer can accept a sample.
- clear_ovr  input  1  synchronous clear of overrun.
- tx_busy  input  1  UART transmitter busy.
- tx_start  output  1  one-cycle request to send tx_data.
- tx_data  output  8  byte to transmit.
- frame_done  output  1  one-cycle pulse after the last byte completes.
- overrun  output  1  sticky flag: a sample was offered while the framer was busy.

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; seq=0; overrun=0; tx_start=0; tx_data=0; frame_done=0; sample_ready=0 during the reset cycle, 1 from the first cycle after reset is released. Reset mid-frame aborts the frame immediately, and no further tx_start is issued.
- sample_ready=1 only in IDLE.
- Capture: in IDLE with sample_valid=1, latch sample_in and the current seq, compute chk, and go to SEND with byte index 0.
  - chk = (HEADER + seq + sample[15:8] + sample[7:0]) mod 256.
- sample_valid=1 in any non-IDLE state sets overrun. The sample is dropped and the frame in progress is unaffected.
- Overrun precedence: clear_ovr=1 clears overrun; if an overrun event occurs in the same cycle, set wins.
- Byte order: index 0 HEADER, 1 seq, 2 sample[15:8], 3 sample[7:0], 4 chk.
- tx_data holds the current byte from the SEND cycle until leaving WAIT_LO.
- States:
  - IDLE: wait for capture.
  - SEND: if tx_busy=0, assert tx_start for exactly one cycle, clear the timeout counter, go to WAIT_HI. If tx_busy=1, stay in SEND with tx_start=0.
  - WAIT_HI: if tx_busy=1, go to WAIT_LO. Otherwise increment the timeout counter; when it reaches ACK_TIMEOUT, return to SEND (retransmit the same byte).
  - WAIT_LO: when tx_busy=0 and index<4, increment index and go to SEND. When tx_busy=0 and index=4, go to DONE.
  - DONE: frame_done=1 for one cycle; seq increments, wrapping 8'hFF to 8'h00; return to IDLE. sample_ready rises the following cycle.
- A sample_valid held high in DONE counts as an overrun. It is captured only once the framer is back in IDLE.
- Latency: capture cycle to first tx_start is 1 cycle when tx_busy=0. Minimum IDLE-to-IDLE turnaround is 5 bytes of UART time plus 3 cycles per byte plus 2.
- No arithmetic overflow is flagged; chk and seq are mod-256.

Test Plan:
- Reset then sample_in=16'h1234, valid for one cycle, with a UART model that raises busy 1 cycle after start for 20 cycles -> tx_data sequence A5,00,12,34,EB; exactly 5 tx_start pulses; frame_done one pulse; sample_ready returns to 1.
- Second frame sample_in=16'hFFFF -> A5,01,FF,FF,A4; seq wrap: after 256 frames the SEQ byte reads 00 again.
- sample_valid pulsed during byte 2 of a frame -> overrun=1; the current frame bytes are unchanged; clear_ovr=1 -> overrun=0 next cycle; simultaneous clear_ovr and a new overrun event -> overrun stays 1.
- UART model ignores the first tx_start of the MSB byte (busy never rises) -> after ACK_TIMEOUT=64 cycles tx_start re-pulses with tx_data=8'h12; the frame completes correctly.
- tx_busy held 1 when the sample is captured -> no tx_start until busy falls, then start within 1 cycle.
- reset=0 asserted while in WAIT_LO of byte 3 -> next cycle state is IDLE, tx_start=0, seq=0, overrun=0; a new sample 16'h0001 afterwards yields A5,00,00,01,A6.

Source files
------------

// File: rtl/sample_framer.sv
// Serialises one 16-bit averaged sample into a HEADER/SEQ/MSB/LSB/CHK frame and
// feeds the bytes to the UART transmitter over its tx_start/tx_busy handshake.
module sample_framer #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        clear_ovr,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned   CW       = $clog2(ACK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEND    = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_WAIT_LO = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    r_idx;
  logic [7:0]    r_seq;
  logic [7:0]    r_frm_seq;
  logic [7:0]    r_msb;
  logic [7:0]    r_lsb;
  logic [7:0]    r_chk;
  logic [CW-1:0] r_cnt;
  logic          r_tx_start;
  logic [7:0]    r_tx_data;
  logic          r_ready;
  logic          r_overrun;

  logic [2:0] w_next_idx;
  logic [7:0] w_next_byte;
  logic [7:0] w_chk;
  logic       w_ovr_evt;

  // Checksum is computed from the live inputs so it is ready in the capture cycle.
  assign w_chk      = HEADER + r_seq + sample_in[15:8] + sample_in[7:0];
  assign w_next_idx = r_idx + 3'd1;
  assign w_ovr_evt  = sample_valid && (r_state != S_IDLE);

  // NOTE: the default assignment up front means no path leaves w_next_byte unassigned, so no latch.
  always_comb begin
    w_next_byte = r_chk;
    case (w_next_idx)
      3'd1:    w_next_byte = r_frm_seq;
      3'd2:    w_next_byte = r_msb;
      3'd3:    w_next_byte = r_lsb;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and clears the data registers too, so tx_data reads 0 after reset.
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_seq      <= 8'd0;
      r_frm_seq  <= 8'd0;
      r_msb      <= 8'd0;
      r_lsb      <= 8'd0;
      r_chk      <= 8'd0;
      r_cnt      <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'd0;
      r_ready    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch below sees the pre-edge values.
      r_tx_start <= 1'b0;

      if (w_ovr_evt)      r_overrun <= 1'b1;
      else if (clear_ovr) r_overrun <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (sample_valid) begin
            r_frm_seq <= r_seq;
            r_msb     <= sample_in[15:8];
            r_lsb     <= sample_in[7:0];
            r_chk     <= w_chk;
            r_idx     <= 3'd0;
            r_tx_data <= HEADER;
            r_ready   <= 1'b0;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            r_tx_start <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // A transmitter that never acknowledges gets the same byte re-issued.
          if (tx_busy)                r_state <= S_WAIT_LO;
          else if (r_cnt == CNT_LAST) r_state <= S_SEND;
          else                        r_cnt   <= r_cnt + CW'(1);
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            if (r_idx == 3'd4) begin
              r_state <= S_DONE;
            end else begin
              r_idx     <= w_next_idx;
              r_tx_data <= w_next_byte;
              r_state   <= S_SEND;
            end
          end
        end
        S_DONE: begin
          r_seq   <= r_seq + 8'd1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sample_ready = r_ready;
  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign frame_done   = (r_state == S_DONE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: fixed frame vectors, overrun/retransmit/busy/reset corner
// cases, and random samples against an arithmetic frame model with a UART model.
module tb_sample_framer;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        clear_ovr;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_done;
  logic        overrun;

  logic m_busy     = 1'b0;
  logic force_busy = 1'b0;
  assign tx_busy = m_busy | force_busy;

  sample_framer #(.HEADER(HDR), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .clear_ovr(clear_ovr), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // UART model and monitor: busy rises uart_delay cycles after a start, lasts uart_len.
  int         cyc = 0, start_cnt = 0, done_cnt = 0, busy_wait = 0, busy_left = 0;
  int         uart_delay = 1, uart_len = 20, ignore_at = -1;
  logic [7:0] byte_q[$];
  int         start_cyc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) m_busy = 1'b0;
    end else if (busy_wait > 0) begin
      busy_wait--;
      if (busy_wait == 0) begin
        m_busy    = 1'b1;
        busy_left = uart_len;
      end
    end
    if (tx_start) begin
      byte_q.push_back(tx_data);
      start_cyc_q.push_back(cyc);
      if (start_cnt != ignore_at) busy_wait = uart_delay;
      start_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  int n_cmp = 0, n_fail = 0;
  int start_base = 0, byte_base = 0, done_base = 0;
  int ref_seq = 0, nf = 0;

  typedef struct {
    logic [15:0] sample;
    logic [39:0] exp;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [39:0] model_frame(input int seq, input logic [15:0] s);
    int hi  = int'(s) / 256;
    int lo  = int'(s) % 256;
    int chk = (int'(HDR) + seq + hi + lo) % 256;
    return {HDR, 8'(seq), 8'(hi), 8'(lo), 8'(chk)};
  endfunction

  function automatic logic [7:0] get_byte(input int i);
    if (byte_base + i < byte_q.size()) return byte_q[byte_base + i];
    return 8'hxx;
  endfunction

  task automatic start_sample(input logic [15:0] s);
    int k = 0;
    while (!sample_ready && k < 4000) begin
      tick();
      k++;
    end
    check("ready_before_sample", {39'd0, sample_ready}, 40'd1);
    start_base   = start_cnt;
    byte_base    = byte_q.size();
    done_base    = done_cnt;
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_starts(input string tag, input int n);
    int k = 0;
    while (start_cnt - start_base < n && k < 4000) begin
      tick();
      k++;
    end
    check({tag, "_reach_start"}, 40'(start_cnt - start_base >= n), 40'd1);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done_cnt == done_base && k < 4000) begin
      tick();
      k++;
    end
    tick();
    check({tag, "_done_pulses"}, 40'(done_cnt - done_base), 40'd1);
    check({tag, "_ready_back"}, {39'd0, sample_ready}, 40'd1);
  endtask

  task automatic check_frame(input string tag, input logic [39:0] exp);
    check({tag, "_starts"}, 40'(start_cnt - start_base), 40'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_b%0d", tag, i), {32'd0, get_byte(i)}, {32'd0, exp[39-8*i -: 8]});
  endtask

  task automatic finish_frame(input string tag, input logic [39:0] exp);
    wait_done(tag);
    check_frame(tag, exp);
    ref_seq = (ref_seq + 1) % 256;
    nf++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] e;
    logic [15:0] s;
    int base;

    tbl[0] = '{16'h1234, 40'hA5_00_12_34_EB};
    tbl[1] = '{16'hFFFF, 40'hA5_01_FF_FF_A4};
    tbl[2] = '{16'h0000, 40'hA5_02_00_00_A7};
    tbl[3] = '{16'h5A5A, 40'hA5_03_5A_5A_5C};

    reset = 1'b0; sample_in = 16'h0; sample_valid = 1'b0; clear_ovr = 1'b0;
    repeat (3) tick();
    check("rst_ready",      {39'd0, sample_ready}, 40'd0);
    check("rst_tx_start",   {39'd0, tx_start},     40'd0);
    check("rst_tx_data",    {32'd0, tx_data},      40'd0);
    check("rst_frame_done", {39'd0, frame_done},   40'd0);
    check("rst_overrun",    {39'd0, overrun},      40'd0);
    reset = 1'b1;
    tick();
    check("ready_after_rst", {39'd0, sample_ready}, 40'd1);

    // Fixed vectors, slow UART.
    uart_delay = 1; uart_len = 20;
    for (int i = 0; i < 4; i++) begin
      start_sample(tbl[i].sample);
      finish_frame($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Overrun during byte 2 leaves the frame intact; clear, then set-wins.
    uart_len = 4;
    check("ovr_pre", {39'd0, overrun}, 40'd0);
    s = 16'hC3D2;
    e = model_frame(ref_seq, s);
    start_sample(s);
    wait_starts("ovr", 3);
    sample_in = 16'h0BAD; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("ovr_set", {39'd0, overrun}, 40'd1);
    finish_frame("ovr", e);
    check("ovr_sticky", {39'd0, overrun}, 40'd1);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    check("ovr_clear", {39'd0, overrun}, 40'd0);

    s = 16'h7E81;
    e = model_frame(ref_seq, s);
    start_sample(s);
    wait_starts("ovr2", 1);
    sample_valid = 1'b1;
    tick();
    check("ovr2_set", {39'd0, overrun}, 40'd1);
    clear_ovr = 1'b1;
    tick();
    sample_valid = 1'b0; clear_ovr = 1'b0;
    check("ovr_set_wins", {39'd0, overrun}, 40'd1);
    finish_frame("ovr2", e);
    clear_ovr = 1'b1;
    tick();
    clear_ovr = 1'b0;
    check("ovr2_clear", {39'd0, overrun}, 40'd0);

    // The MSB byte's first start is ignored by the UART: it must be re-issued.
    e = model_frame(ref_seq, 16'h1234);
    ignore_at = start_cnt + 2;
    start_sample(16'h1234);
    wait_done("retx");
    ignore_at = -1;
    check("retx_starts", 40'(start_cnt - start_base), 40'd6);
    check("retx_b0", {32'd0, get_byte(0)}, {32'd0, e[39:32]});
    check("retx_b1", {32'd0, get_byte(1)}, {32'd0, e[31:24]});
    check("retx_b2", {32'd0, get_byte(2)}, 40'h12);
    check("retx_b2_again", {32'd0, get_byte(3)}, 40'h12);
    check("retx_b3", {32'd0, get_byte(4)}, {32'd0, e[15:8]});
    check("retx_b4", {32'd0, get_byte(5)}, {32'd0, e[7:0]});
    if (start_cyc_q.size() >= start_base + 4) begin
      base = start_cyc_q[start_base + 3] - start_cyc_q[start_base + 2];
      check("retx_gap_in_range", 40'(base >= TMO && base <= TMO + 3), 40'd1);
    end else begin
      check("retx_gap_present", 40'(start_cyc_q.size()), 40'(start_base + 4));
    end
    ref_seq = (ref_seq + 1) % 256;
    nf++;

    // Busy already high at capture: no start until it falls, then within one cycle.
    s = 16'h4321;
    e = model_frame(ref_seq, s);
    force_busy = 1'b1;
    start_sample(s);
    repeat (10) tick();
    check("busy_hold_no_start", 40'(start_cnt - start_base), 40'd0);
    force_busy = 1'b0;
    tick();
    check("busy_release_start", 40'(start_cnt - start_base), 40'd1);
    finish_frame("busy", e);

    // Random samples and UART timing until the sequence number wraps.
    while (nf < 256) begin
      uart_delay = $urandom_range(1, 3);
      uart_len   = $urandom_range(1, 6);
      s = 16'($urandom);
      e = model_frame(ref_seq, s);
      start_sample(s);
      finish_frame($sformatf("rnd%0d", nf), e);
    end
    uart_delay = 1; uart_len = 6;
    start_sample(16'h1234);
    finish_frame("wrap", 40'hA5_00_12_34_EB);

    // Reset in WAIT_LO of byte 3 aborts the frame and clears seq and overrun.
    start_sample(16'hBEEF);
    wait_starts("rst_mid", 1);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("rst_mid_ovr", {39'd0, overrun}, 40'd1);
    wait_starts("rst_mid", 4);
    base = 0;
    while (!tx_busy && base < 200) begin
      tick();
      base++;
    end
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid_tx_start", {39'd0, tx_start},     40'd0);
    check("rst_mid_overrun",  {39'd0, overrun},      40'd0);
    check("rst_mid_ready",    {39'd0, sample_ready}, 40'd0);
    check("rst_mid_done",     {39'd0, frame_done},   40'd0);
    reset = 1'b1;
    base = start_cnt;
    tick();
    check("rst_mid_idle", {39'd0, sample_ready}, 40'd1);
    repeat (30) tick();
    check("rst_mid_no_start", 40'(start_cnt - base), 40'd0);
    ref_seq = 0;
    start_sample(16'h0001);
    finish_frame("post_rst", 40'hA5_00_00_01_A6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
